event_scheduler: RTL and testbench

Round-robin scheduler that collects single-cycle event pulses from NUM_CH event sources, each gated by a per-channel enable, and serialises them onto one downstream event-report port with a valid/ready handshake. It sits between a bank of event monitors and the shared event consumer (logging or interrupt logic), so that only one monitor reports per accepted transfer. Each channel has one pending slot; events that hit an already-pending slot are counted in a saturating drop counter.

---
 rtl/event_scheduler.sv | 109 ++++++++++
 tb/tb_event_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/event_scheduler.sv
// event_scheduler: round-robin serialiser of gated event pulses onto a
// single valid/ready report port, with one pending slot per channel.
module event_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_enable,
  input  logic [NUM_CH-1:0]         ev_in,
  input  logic                      clear_drop,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic [NUM_CH-1:0]         pending,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int SUM_W = CNT_W + 5;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_next;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  out_ch_next;
  logic [NUM_CH-1:0] pend_eff;
  logic [NUM_CH-1:0] acc;
  logic [NUM_CH-1:0] consumed;
  logic [NUM_CH-1:0] drop;
  logic [NUM_CH-1:0] pending_next;
  logic              found;
  logic              load;
  logic              out_valid_next;
  logic [SUM_W-1:0]  sum;
  logic [CNT_W-1:0]  drop_next;

  assign pend_eff = pending & ch_enable;
  assign acc      = ev_in & ch_enable;
  assign load     = (!out_valid || out_ready) && (|pend_eff);

  // search starts at ptr and wraps, so the last winner goes to the back
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (!found && pend_eff[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign consumed = load ? (NUM_CH'(1) << winner) : '0;

  assign pending_next = ch_enable & ((pending & ~consumed) | acc);
  assign drop         = acc & pending & ~consumed;

  always_comb begin
    out_valid_next = out_valid;
    out_ch_next    = out_ch;
    ptr_next       = ptr;
    if (load) begin
      out_valid_next = 1'b1;
      out_ch_next    = winner;
      ptr_next       = (winner == IDX_W'(NUM_CH - 1)) ?
                       '0 : winner + IDX_W'(1);
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  // wide sum lets overflow show in the top bits before saturating
  always_comb begin
    sum = SUM_W'(drop_cnt);
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sum + SUM_W'(drop[i]);
    end
    if (clear_drop) begin
      drop_next = '0;
    end else if (|sum[SUM_W-1:CNT_W]) begin
      drop_next = '1;
    end else begin
      drop_next = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      drop_cnt  <= '0;
      ptr       <= '0;
    end else begin
      pending   <= pending_next;
      out_valid <= out_valid_next;
      out_ch    <= out_ch_next;
      drop_cnt  <= drop_next;
      ptr       <= ptr_next;
    end
  end

  assign busy = (|pending) | out_valid;

endmodule

// File: tb/tb_event_scheduler.sv
// tb_event_scheduler: directed and random stimulus against a queue-based
// reference model; a monitor checks reports and state at each negedge.
module tb_event_scheduler;

  localparam int N    = 4;
  localparam int CW   = 4;
  localparam int MAXC = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] ch_enable;
  logic [N-1:0] ev_in;
  logic         clear_drop;
  logic         out_ready;
  logic         out_valid;
  logic [1:0]   out_ch;
  logic [N-1:0] pending;
  logic [CW-1:0] drop_cnt;
  logic         busy;

  event_scheduler #(.NUM_CH(N), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .ch_enable  (ch_enable),
    .ev_in      (ev_in),
    .clear_drop (clear_drop),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .pending    (pending),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state: slot flags, presented report, rotation start, drops
  bit m_slot [N];
  bit m_valid;
  int m_ptr;
  int m_drop;
  int exp_q [$];

  function automatic int slot_vec();
    int v = 0;
    for (int i = 0; i < N; i++) if (m_slot[i]) v += (1 << i);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_slot[i] = 1'b0;
    m_valid = 1'b0;
    m_ptr   = 0;
    m_drop  = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input int en, input int ev,
                            input bit clr, input bit rdy);
    int win   = -1;
    int drops = 0;
    bit keep;
    bit hit;
    if (!m_valid || rdy) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_ptr + k) % N;
        if (win < 0 && m_slot[c] && ((en >> c) & 1) == 1) win = c;
      end
    end
    if (win >= 0) begin
      m_valid = 1'b1;
      m_ptr   = (win + 1) % N;
      exp_q.push_back(win);
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      keep = m_slot[i] && (i != win);
      hit  = ((ev >> i) & 1) == 1 && ((en >> i) & 1) == 1;
      if (hit && keep) drops++;
      m_slot[i] = ((en >> i) & 1) == 1 && (keep || hit);
    end
    if (clr) m_drop = 0;
    else m_drop = (m_drop + drops > MAXC) ? MAXC : m_drop + drops;
  endtask

  task automatic step(input int en, input int ev,
                      input bit clr, input bit rdy);
    ch_enable  = N'(en);
    ev_in      = N'(ev);
    clear_drop = clr;
    out_ready  = rdy;
    @(posedge clk);
    model_step(en, ev, clr, rdy);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // monitor: reports popped on handshake, held reports must not move
  bit prev_v;
  bit prev_r;
  int prev_ch;
  initial begin
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("pending", int'(pending), slot_vec());
        chk("drop_cnt", int'(drop_cnt), m_drop);
        chk("busy", int'(busy), int'(m_valid || slot_vec() != 0));
        if (prev_v && !prev_r) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_ch", int'(out_ch), prev_ch);
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("report_expected", 1, 0);
          end else begin
            chk("report_ch", int'(out_ch), exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        prev_v  = out_valid;
        prev_r  = out_ready;
        prev_ch = int'(out_ch);
      end
    end
  end

  initial begin
    reset      = 1'b1;
    ch_enable  = '0;
    ev_in      = '0;
    clear_drop = 1'b0;
    out_ready  = 1'b0;
    do_reset();

    // single event, two-cycle latency
    step(15, 1, 0, 1);
    chk("t1_valid_early", int'(out_valid), 0);
    step(15, 0, 0, 1);
    chk("t1_valid", int'(out_valid), 1);
    chk("t1_ch", int'(out_ch), 0);
    chk("t1_pending", int'(pending), 0);
    step(15, 0, 0, 1);
    chk("t1_valid_off", int'(out_valid), 0);
    chk("t1_drop", int'(drop_cnt), 0);

    // all channels: rotate 0..3 back to back
    do_reset();
    step(15, 15, 0, 1);
    for (int j = 0; j < N; j++) begin
      step(15, 0, 0, 1);
      chk("t2_valid", int'(out_valid), 1);
      chk("t2_ch", int'(out_ch), j);
    end
    step(15, 0, 0, 1);
    chk("t2_idle_valid", int'(out_valid), 0);
    chk("t2_idle_busy", int'(busy), 0);

    // held level on ch2 under backpressure
    do_reset();
    for (int j = 0; j < 5; j++) step(15, 4, 0, 0);
    chk("t3_valid", int'(out_valid), 1);
    chk("t3_ch", int'(out_ch), 2);
    chk("t3_pending", int'(pending), 4);
    chk("t3_drop", int'(drop_cnt), 3);
    step(15, 0, 1, 0);
    chk("t3_clear", int'(drop_cnt), 0);
    for (int j = 0; j < 3; j++) step(15, 0, 0, 1);
    chk("t3_drained", int'(busy), 0);

    // disabling a channel clears its slot, report in flight survives
    do_reset();
    step(15, 1, 0, 0);
    step(15, 2, 0, 0);
    chk("t4_pending1", int'(pending), 2);
    step(13, 0, 0, 0);
    chk("t4_cleared", int'(pending), 0);
    for (int j = 0; j < 3; j++) begin
      step(13, 2, 0, 0);
      chk("t4_ign_pend", int'(pending), 0);
      chk("t4_ign_drop", int'(drop_cnt), 0);
    end
    chk("t4_held_ch", int'(out_ch), 0);
    step(15, 0, 0, 1);
    step(15, 0, 0, 1);
    chk("t4_done", int'(out_valid), 0);

    // saturation: 22 strobes -> 20 drops -> clamp at 15
    do_reset();
    for (int j = 0; j < 22; j++) step(15, 8, 0, 0);
    chk("t5_sat", int'(drop_cnt), MAXC);
    step(15, 8, 1, 0);
    chk("t5_clear", int'(drop_cnt), 0);

    // reset mid-transfer
    do_reset();
    step(15, 1, 0, 0);
    step(15, 10, 0, 0);
    chk("t6_valid", int'(out_valid), 1);
    chk("t6_pending", int'(pending), 10);
    do_reset();
    step(15, 8, 0, 1);
    step(15, 0, 0, 1);
    chk("t6_valid_after", int'(out_valid), 1);
    chk("t6_ch_after", int'(out_ch), 3);
    step(15, 0, 0, 1);

    // random phase
    for (int j = 0; j < 3000; j++) begin
      int en;
      en = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : 15;
      if ($urandom_range(0, 299) == 0) do_reset();
      step(en, int'($urandom_range(0, 15)),
           $urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0);
    end
    for (int j = 0; j < 10; j++) step(15, 0, 0, 1);
    @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_idle", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
